progmem_loader: RTL and testbench

Program memory for the multi-cycle RISC-V core, sitting directly upstream of the CPU's instruction fetch.
- It accepts a byte stream (from the UART receiver or the testbench) and assembles bytes little-endian into 32-bit words.
- It writes the assembled words into a word-addressed RAM and holds the CPU in reset until the load completes.
- It then serves CPU fetches through the mem_addr / mem_rstrb / mem_rdata interface with one-cycle registered read latency.

---
 rtl/progmem_loader.sv | 160 ++++++++++++++++
 tb/tb_progmem_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/progmem_loader.sv
// Program memory for the multi-cycle RISC-V core: assembles a little-endian byte
// stream into 32-bit words, holds the CPU in reset until loaded, then serves fetches.
module progmem_loader #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              loading,
    output logic              load_done,
    output logic              cpu_rst,
    input  logic [31:0]       mem_addr,
    input  logic              mem_rstrb,
    output logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(MEM_WORDS);

    state_t          state_r, state_s;
    logic [ADDR_W:0] cnt_r, cnt_s, ptr_r, ptr_s;
    logic [ADDR_W:0] clamped_s, start_cnt_s;
    logic [31:0]     word_r, word_s;
    logic            pending_r, pending_s;
    logic            take_s, wr_s;
    logic            byte_ready_r, loading_r, load_done_r, cpu_rst_r;
    logic [31:0]     rdata_r;
    logic [31:0]     mem [0:MEM_WORDS-1];
    logic            addr_unused_s;

    assign addr_unused_s = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    // Next-state, byte assembly and word-pointer logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        ptr_s     = ptr_r;
        word_s    = word_r;
        pending_s = pending_r;
        wr_s      = 1'b0;
        take_s    = byte_valid && byte_ready_r;
        clamped_s = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
        // A restart from DONE parks the clamped count and finishes the start from IDLE
        start_cnt_s = load_start ? clamped_s : cnt_r;
        case (state_r)
            IDLE: begin
                if (load_start || pending_r) begin
                    cnt_s     = start_cnt_s;
                    ptr_s     = '0;
                    pending_s = 1'b0;
                    state_s   = (start_cnt_s == '0) ? DONE : B0;
                end else begin
                    state_s = IDLE;
                end
            end
            B0: begin
                if (take_s) begin
                    word_s[7:0] = byte_data;
                    state_s     = B1;
                end else begin
                    state_s = B0;
                end
            end
            B1: begin
                if (take_s) begin
                    word_s[15:8] = byte_data;
                    state_s      = B2;
                end else begin
                    state_s = B1;
                end
            end
            B2: begin
                if (take_s) begin
                    word_s[23:16] = byte_data;
                    state_s       = B3;
                end else begin
                    state_s = B2;
                end
            end
            B3: begin
                if (take_s) begin
                    word_s[31:24] = byte_data;
                    state_s       = WRITE;
                end else begin
                    state_s = B3;
                end
            end
            WRITE: begin
                wr_s    = 1'b1;
                ptr_s   = ptr_r + 1'b1;
                state_s = ((ptr_r + 1'b1) == cnt_r) ? DONE : B0;
            end
            DONE: begin
                if (load_start) begin
                    cnt_s     = clamped_s;
                    pending_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            ptr_r        <= '0;
            word_r       <= 32'h0000_0000;
            pending_r    <= 1'b0;
            byte_ready_r <= 1'b0;
            loading_r    <= 1'b0;
            load_done_r  <= 1'b0;
            cpu_rst_r    <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ptr_r        <= ptr_s;
            word_r       <= word_s;
            pending_r    <= pending_s;
            byte_ready_r <= state_s inside {B0, B1, B2, B3};
            loading_r    <= state_s inside {B0, B1, B2, B3, WRITE};
            load_done_r  <= (state_s == DONE);
            // Released only after a full cycle in DONE, so the CPU sees a settled RAM
            cpu_rst_r    <= !((state_r == DONE) && !load_start);
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_s && !rst) begin
            mem[ptr_r[ADDR_W-1:0]] <= word_r;
        end
    end

    // Registered read port, read-first against a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (mem_rstrb) begin
            rdata_r <= mem[mem_addr[ADDR_W+1:2]];
        end
    end

    assign byte_ready = byte_ready_r;
    assign loading    = loading_r;
    assign load_done  = load_done_r;
    assign cpu_rst    = cpu_rst_r;
    assign mem_rdata  = rdata_r;
endmodule

// File: tb/tb_progmem_loader.sv
// Directed self-checking bench for progmem_loader: load timing, gapped bytes,
// abort by reset, zero/oversized counts, read wrap and read/write collision.
module tb_progmem_loader;
    localparam int MEM_WORDS = 256;
    localparam int ADDR_W    = 8;
    localparam int LIMIT     = 3000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_words = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready, loading, load_done, cpu_rst;
    logic [31:0]       mem_addr = 32'h0;
    logic              mem_rstrb = 1'b0;
    logic [31:0]       mem_rdata;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  stim [0:7];
    bit          use_ramp = 1'b0;
    logic [7:0]  ramp_off = 8'h00;
    int          collide_cyc = -1;
    logic [31:0] collide_addr = 32'h0;
    logic [31:0] snoop = 32'h0;

    progmem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_words(load_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .loading(loading), .load_done(load_done), .cpu_rst(cpu_rst),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic do_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // done_at = rising edges from the load_start edge to the load_done edge
    task automatic run_load(input logic [ADDR_W:0] words, input int nbytes, input bit gaps,
                            input bit wait_done, output int done_at, output int rdy_low);
        int cyc;
        int idx;
        bit phase;
        bit rdy;
        cyc = 0; idx = 0; rdy_low = 0; done_at = -1; phase = gaps;
        load_words = words;
        load_start = 1'b1;
        @(negedge clk); cyc++;
        load_start = 1'b0;
        while (idx < nbytes && cyc < LIMIT) begin
            byte_data  = use_ramp ? 8'(idx) + ramp_off : stim[idx % 8];
            byte_valid = !phase;
            rdy = byte_ready;
            if (!rdy) rdy_low++;
            @(negedge clk); cyc++;
            if (rdy) begin
                if (phase) phase = 1'b0;
                else begin idx++; phase = gaps; end
            end
        end
        byte_valid = 1'b0;
        while (wait_done && done_at < 0 && cyc < LIMIT) begin
            if (load_done) done_at = cyc - 1;
            else begin
                if (!byte_ready) rdy_low++;
                mem_rstrb = (cyc == collide_cyc);
                mem_addr  = collide_addr;
                @(negedge clk); cyc++;
                if (cyc == collide_cyc + 1) snoop = mem_rdata;
                mem_rstrb = 1'b0;
            end
        end
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        data = mem_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (cpu_rst !== 1'b1)    begin bad++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
        total++; if (loading !== 1'b0)    begin bad++; $display("FAIL reset_loading got=%b exp=0", loading); end
        total++; if (load_done !== 1'b0)  begin bad++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int d, r;
        logic [31:0] v;
        stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h50; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
        run_load(9'd2, 8, 1'b0, 1'b1, d, r);
        total++; if (d !== 10) begin bad++; $display("FAIL basic_done_latency got=%0d exp=10", d); end
        total++; if (r !== 2)  begin bad++; $display("FAIL basic_ready_low got=%0d exp=2", r); end
        total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL basic_cpu_rst_hold got=%b exp=1", cpu_rst); end
        total++; if (loading !== 1'b0) begin bad++; $display("FAIL basic_loading got=%b exp=0", loading); end
        @(negedge clk);
        total++; if (cpu_rst !== 1'b0) begin bad++; $display("FAIL basic_cpu_rst_release got=%b exp=0", cpu_rst); end
        read_word(32'h4, v);
        total++; if (v !== 32'h0010_0093) begin bad++; $display("FAIL basic_read_w1 got=%h exp=00100093", v); end
        mem_addr = 32'h0;
        @(negedge clk);
        total++; if (mem_rdata !== 32'h0010_0093) begin bad++; $display("FAIL basic_rdata_hold got=%h exp=00100093", mem_rdata); end
        read_word(32'h0, v);
        total++; if (v !== 32'h0050_0013) begin bad++; $display("FAIL basic_read_w0 got=%h exp=00500013", v); end
    endtask

    task automatic test_gapped_load();
        int d, r;
        logic [31:0] v;
        do_rst();
        run_load(9'd2, 8, 1'b1, 1'b1, d, r);
        total++; if (d !== 18) begin bad++; $display("FAIL gap_done_latency got=%0d exp=18", d); end
        total++; if (r !== 2)  begin bad++; $display("FAIL gap_ready_low got=%0d exp=2", r); end
        read_word(32'h0, v);
        total++; if (v !== 32'h0050_0013) begin bad++; $display("FAIL gap_read_w0 got=%h exp=00500013", v); end
        read_word(32'h4, v);
        total++; if (v !== 32'h0010_0093) begin bad++; $display("FAIL gap_read_w1 got=%h exp=00100093", v); end
    endtask

    task automatic test_abort();
        int d, r;
        logic [31:0] v;
        do_rst();
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        stim[4] = 8'h11; stim[5] = 8'h22; stim[6] = 8'h33; stim[7] = 8'h44;
        run_load(9'd2, 6, 1'b0, 1'b0, d, r);
        do_rst();
        total++; if (loading !== 1'b0)   begin bad++; $display("FAIL abort_loading got=%b exp=0", loading); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL abort_load_done got=%b exp=0", load_done); end
        total++; if (cpu_rst !== 1'b1)   begin bad++; $display("FAIL abort_cpu_rst got=%b exp=1", cpu_rst); end
        stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
        run_load(9'd1, 4, 1'b0, 1'b1, d, r);
        total++; if (d !== 5) begin bad++; $display("FAIL abort_reload_latency got=%0d exp=5", d); end
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL abort_reload_done got=%b exp=1", load_done); end
        read_word(32'h0, v);
        total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL abort_read_w0 got=%h exp=deadbeef", v); end
        read_word(32'h4, v);
        total++; if (v !== 32'h0010_0093) begin bad++; $display("FAIL abort_read_w1 got=%h exp=00100093", v); end
    endtask

    task automatic test_zero_and_restart();
        int d, r;
        do_rst();
        run_load(9'd0, 0, 1'b0, 1'b1, d, r);
        total++; if (d !== 0) begin bad++; $display("FAIL zero_done_latency got=%0d exp=0", d); end
        @(negedge clk);
        total++; if (cpu_rst !== 1'b0)    begin bad++; $display("FAIL zero_cpu_rst got=%b exp=0", cpu_rst); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL zero_byte_ready got=%b exp=0", byte_ready); end
        load_words = 9'd0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL restart_load_done got=%b exp=0", load_done); end
        total++; if (cpu_rst !== 1'b1)   begin bad++; $display("FAIL restart_cpu_rst got=%b exp=1", cpu_rst); end
        @(negedge clk);
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL restart_redone got=%b exp=1", load_done); end
    endtask

    task automatic test_full_and_wrap();
        int d, r;
        logic [31:0] v;
        do_rst();
        use_ramp = 1'b1;
        ramp_off = 8'h00;
        run_load(9'(MEM_WORDS + 5), 4 * MEM_WORDS, 1'b0, 1'b1, d, r);
        total++; if (d !== 5 * MEM_WORDS) begin bad++; $display("FAIL full_done_latency got=%0d exp=%0d", d, 5 * MEM_WORDS); end
        total++; if (r !== MEM_WORDS) begin bad++; $display("FAIL full_write_cycles got=%0d exp=%0d", r, MEM_WORDS); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL full_byte_ready got=%b exp=0", byte_ready); end
        read_word(32'(4 * (MEM_WORDS - 1)), v);
        total++; if (v !== 32'hFFFE_FDFC) begin bad++; $display("FAIL full_read_last got=%h exp=fffefdfc", v); end
        read_word(32'(4 * MEM_WORDS + 8), v);
        total++; if (v !== 32'h0B0A_0908) begin bad++; $display("FAIL wrap_read got=%h exp=0b0a0908", v); end
    endtask

    task automatic test_collision();
        int d, r;
        logic [31:0] v;
        do_rst();
        use_ramp = 1'b1;
        ramp_off = 8'h80;
        collide_cyc = 20;
        collide_addr = 32'hC;
        run_load(9'd4, 16, 1'b0, 1'b1, d, r);
        collide_cyc = -1;
        use_ramp = 1'b0;
        total++; if (d !== 20) begin bad++; $display("FAIL coll_done_latency got=%0d exp=20", d); end
        total++; if (snoop !== 32'h0F0E_0D0C) begin bad++; $display("FAIL coll_read_first got=%h exp=0f0e0d0c", snoop); end
        read_word(32'hC, v);
        total++; if (v !== 32'h8F8E_8D8C) begin bad++; $display("FAIL coll_new_data got=%h exp=8f8e8d8c", v); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_abort();
        test_zero_and_restart();
        test_full_and_wrap();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
